// File: rtl/pc_branch_unit.sv
// Next-PC / fetch-PC stage: owns the PC register and resolves EX redirects
// (JR > J/JAL > taken branch). If instruction memory is busy, it parks the
// redirect in a pending register. It pulses flush on every accepted redirect.
module pc_branch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             imem_ready_i,
  input  logic             stall_i,
  input  logic [31:0]      ex_pc4_i,
  input  logic             br_valid_i,
  input  logic             br_taken_i,
  input  logic [31:0]      br_offset_i,
  input  logic             jmp_valid_i,
  input  logic [25:0]      jmp_index_i,
  input  logic             jr_valid_i,
  input  logic [31:0]      jr_target_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      pc4_o,
  output logic             if_valid_o,
  output logic             flush_o,
  output logic             addr_err_o,
  output logic [CNT_W-1:0] redir_cnt_o
);

  typedef enum logic [1:0] {StBoot, StRun, StPend, StErr} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic             flush_q, flush_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             br_take;
  logic             br_sel;
  logic             redir;
  logic [31:0]      target;

  // Redirect decode and target selection, JR has highest priority
  always_comb begin
    br_take = br_valid_i & br_taken_i;
    redir   = jr_valid_i | jmp_valid_i | br_take;
    br_sel  = br_take & ~jr_valid_i & ~jmp_valid_i;
    if (jr_valid_i) begin
      target = jr_target_i;
    end else if (jmp_valid_i) begin
      target = {ex_pc4_i[31:28], jmp_index_i, 2'b00};
    end else begin
      target = ex_pc4_i + br_offset_i;
    end
  end

  // Next-state logic for PC, pending target, flush, error and redirect counter
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pend_d  = pend_q;
    flush_d = 1'b0;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StBoot: state_d = StRun;
      StRun, StPend: begin
        if (redir) begin
          flush_d = 1'b1;
          if (target[1:0] != 2'b00) begin
            state_d = StErr;
            err_d   = 1'b1;
          end else begin
            if (br_sel && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
            if (imem_ready_i) begin
              pc_d    = target;
              state_d = StRun;
            end else begin
              // Newer redirect replaces any older parked target
              pend_d  = target;
              state_d = StPend;
            end
          end
        end else if (state_q == StPend) begin
          // Stall has no effect while a redirect is parked
          if (imem_ready_i) begin
            pc_d    = pend_q;
            state_d = StRun;
          end
        end else if (imem_ready_i && !stall_i) begin
          pc_d = pc_q + 32'd4;
        end
      end
      StErr: state_d = StErr;
      default: state_d = StBoot;
    endcase
  end

  // State registers, asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StBoot;
      pc_q    <= RESET_PC;
      pend_q  <= 32'h0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      flush_q <= flush_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Output mapping
  always_comb begin
    pc_o        = pc_q;
    pc4_o       = pc_q + 32'd4;
    if_valid_o  = (state_q == StRun) || (state_q == StPend);
    flush_o     = flush_q;
    addr_err_o  = err_q;
    redir_cnt_o = cnt_q;
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a reference model pushes expected outputs
// at every rising edge, and a monitor pops and compares them on the falling edge.
module tb_pc_branch_unit;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam int unsigned CntW    = 16;
  localparam logic [CntW-1:0] CntMax = {CntW{1'b1}};

  logic            clk = 1'b0;
  logic            rst_n;
  logic            imem_ready_i, stall_i;
  logic [31:0]     ex_pc4_i, br_offset_i, jr_target_i;
  logic            br_valid_i, br_taken_i, jmp_valid_i, jr_valid_i;
  logic [25:0]     jmp_index_i;
  logic [31:0]     pc_o, pc4_o;
  logic            if_valid_o, flush_o, addr_err_o;
  logic [CntW-1:0] redir_cnt_o;

  pc_branch_unit #(.RESET_PC(ResetPc), .CNT_W(CntW)) dut (
    .clk(clk), .rst_n(rst_n), .imem_ready_i(imem_ready_i), .stall_i(stall_i),
    .ex_pc4_i(ex_pc4_i), .br_valid_i(br_valid_i), .br_taken_i(br_taken_i),
    .br_offset_i(br_offset_i), .jmp_valid_i(jmp_valid_i), .jmp_index_i(jmp_index_i),
    .jr_valid_i(jr_valid_i), .jr_target_i(jr_target_i), .pc_o(pc_o), .pc4_o(pc4_o),
    .if_valid_o(if_valid_o), .flush_o(flush_o), .addr_err_o(addr_err_o),
    .redir_cnt_o(redir_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]     pc;
    logic            valid;
    logic            flush;
    logic            err;
    logic [CntW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask

  // Reference model: booleans for "just booted", "dead", and "target parked"
  logic [31:0]     m_pc, m_pend_tgt, m_tgt;
  logic            m_boot, m_dead, m_pend, m_flush, m_redir, m_is_br;
  logic [CntW-1:0] m_cnt;

  initial forever begin
    @(posedge clk);
    if (!rst_n) begin
      m_pc = ResetPc; m_boot = 1'b1; m_dead = 1'b0; m_pend = 1'b0;
      m_flush = 1'b0; m_cnt = '0;
    end else if (m_dead) begin
      m_flush = 1'b0;
    end else if (m_boot) begin
      m_boot = 1'b0; m_flush = 1'b0;
    end else begin
      m_flush = 1'b0;
      m_redir = jr_valid_i || jmp_valid_i || (br_valid_i && br_taken_i);
      m_is_br = !jr_valid_i && !jmp_valid_i;
      if (jr_valid_i)       m_tgt = jr_target_i;
      else if (jmp_valid_i) m_tgt = (ex_pc4_i & 32'hF000_0000) | ({6'd0, jmp_index_i} * 4);
      else                  m_tgt = ex_pc4_i + br_offset_i;
      if (m_redir) begin
        m_flush = 1'b1;
        if (m_tgt % 4 != 0) begin
          m_dead = 1'b1;
        end else begin
          if (m_is_br && m_cnt != CntMax) m_cnt = m_cnt + 1;
          if (imem_ready_i) begin
            m_pc = m_tgt; m_pend = 1'b0;
          end else begin
            m_pend_tgt = m_tgt; m_pend = 1'b1;
          end
        end
      end else if (m_pend) begin
        if (imem_ready_i) begin
          m_pc = m_pend_tgt; m_pend = 1'b0;
        end
      end else if (imem_ready_i && !stall_i) begin
        m_pc = m_pc + 4;
      end
    end
    exp_q.push_back('{pc: m_pc, valid: !m_boot && !m_dead, flush: m_flush, err: m_dead,
                      cnt: m_cnt});
  end

  // Monitor: compare on the falling edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pc", pc_o, e.pc);
      chk("pc4", pc4_o, e.pc + 32'd4);
      chk("if_valid", {31'd0, if_valid_o}, {31'd0, e.valid});
      chk("flush", {31'd0, flush_o}, {31'd0, e.flush});
      chk("addr_err", {31'd0, addr_err_o}, {31'd0, e.err});
      chk("redir_cnt", {16'd0, redir_cnt_o}, {16'd0, e.cnt});
    end
  end

  task automatic idle(input logic ready);
    imem_ready_i = ready; stall_i = 1'b0;
    br_valid_i = 1'b0; br_taken_i = 1'b0; jmp_valid_i = 1'b0; jr_valid_i = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle(1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_pc", pc_o, ResetPc);
    chk("async_reset_err", {31'd0, addr_err_o}, 32'd0);
    cycles(2);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(1'b1);
    ex_pc4_i = 32'h0; br_offset_i = 32'h0; jr_target_i = 32'h0; jmp_index_i = '0;
    cycles(2);
    rst_n = 1'b1;
    cycles(4);                              // BOOT then 0,4,8,C

    // Taken branch backwards
    ex_pc4_i = 32'h100; br_offset_i = 32'hFFFF_FFF0; br_valid_i = 1'b1; br_taken_i = 1'b1;
    cycles(1);
    idle(1'b1); cycles(2);

    // Jump while memory busy, released three cycles later
    idle(1'b0);
    ex_pc4_i = 32'h8000_0010; jmp_index_i = 26'h0000040; jmp_valid_i = 1'b1;
    cycles(1);
    idle(1'b0); cycles(3);
    idle(1'b1); cycles(2);

    // JR beats branch, stall ignored by redirect
    jr_valid_i = 1'b1; jr_target_i = 32'h2000; br_valid_i = 1'b1; br_taken_i = 1'b1;
    ex_pc4_i = 32'h40; br_offset_i = 32'h8; stall_i = 1'b1;
    cycles(1);
    idle(1'b1); stall_i = 1'b1; cycles(2);  // stall holds PC
    idle(1'b1);
    br_taken_i = 1'b1; cycles(2);           // taken without valid: no effect
    idle(1'b1);

    // Wrap at top of address space
    jr_valid_i = 1'b1; jr_target_i = 32'hFFFF_FFFC; cycles(1);
    idle(1'b1); cycles(2);

    // Misaligned JR: sticky error, frozen PC, requests ignored, reset recovers
    jr_valid_i = 1'b1; jr_target_i = 32'h2002; cycles(1);
    idle(1'b1); br_valid_i = 1'b1; br_taken_i = 1'b1; jr_valid_i = 1'b1;
    jr_target_i = 32'h3000; cycles(5);
    do_reset();
    cycles(3);

    // Randomized traffic with aligned targets
    for (int i = 0; i < 3000; i++) begin
      imem_ready_i = ($urandom_range(0, 9) < 7);
      stall_i      = ($urandom_range(0, 9) < 2);
      br_valid_i   = ($urandom_range(0, 9) < 3);
      br_taken_i   = $urandom_range(0, 1) != 0;
      jmp_valid_i  = ($urandom_range(0, 19) == 0);
      jr_valid_i   = ($urandom_range(0, 19) == 0);
      ex_pc4_i     = $urandom() & 32'hFFFF_FFFC;
      br_offset_i  = $urandom() & 32'hFFFF_FFFC;
      jr_target_i  = $urandom() & 32'hFFFF_FFFC;
      jmp_index_i  = 26'($urandom());
      cycles(1);
    end
    idle(1'b1); cycles(3);

    // Counter saturation
    do_reset();
    cycles(1);
    ex_pc4_i = 32'h100; br_offset_i = 32'h0; br_valid_i = 1'b1; br_taken_i = 1'b1;
    cycles((1 << CntW) + 2);
    idle(1'b1); cycles(2);
    chk("cnt_saturated", {16'd0, redir_cnt_o}, {16'd0, CntMax});
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_branch_unit.md
Name: pc_branch_unit

Overview:
- Next-PC / fetch-PC stage of the pipelined CPU.
- Consumes the sign-extended, word-shifted branch offset (32-bit, already <<2) produced by the branch-offset extender, together with jump and jump-register requests from EX.
- Owns the PC register. Drives the fetch address and a fetch-valid flag, and issues flush pulses on redirect.
- Holds redirects that arrive while instruction memory is busy.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- imem_ready_i  input  1  instruction memory accepted the current pc_o this cycle.
- stall_i  input  1  pipeline hazard stall; hold PC.
- ex_pc4_i  input  32  PC+4 of the instruction in EX.
- br_valid_i  input  1  conditional branch resolved in EX this cycle.
- br_taken_i  input  1  branch condition true; qualified by br_valid_i.
- br_offset_i  input  32  sign-extended offset, already shifted left 2.
- jmp_valid_i  input  1  J/JAL in EX.
- jmp_index_i  input  26  instr_index field.
- jr_valid_i  input  1  JR/JALR in EX.
- jr_target_i  input  32  register target.
- pc_o  output  32  current fetch address.
- pc4_o  output  32  pc_o + 4, combinational, wraps.
- if_valid_o  output  1  pc_o is a valid fetch.
- flush_o  output  1  one-cycle pulse: kill IF/ID contents.
- addr_err_o  output  1  sticky misaligned-target error.
- redir_cnt_o  output  CNT_W  count of applied taken-branch redirects, saturating.

Behaviour:
- Reset (async, rst_n=0):
  - pc_o=RESET_PC, if_valid_o=0, flush_o=0, addr_err_o=0, redir_cnt_o=0.
  - Pending register cleared; state=BOOT.
  - Reset asserted mid-operation discards any pending redirect.
- States: BOOT, RUN, PEND, ERR.
- BOOT: one cycle. Next edge goes to RUN, if_valid_o=1. PC unchanged.
- Redirect request (redir) = jr_valid_i | jmp_valid_i | (br_valid_i & br_taken_i). Priority jr > jmp > branch.
- Target computation:
  - jr: jr_target_i.
  - jmp: {ex_pc4_i[31:28], jmp_index_i, 2'b00}.
  - branch: ex_pc4_i + br_offset_i, modulo 2^32 (carry discarded).
- RUN:
  - redir & target[1:0]!=0: go to ERR, addr_err_o<=1, flush_o<=1 for one cycle, if_valid_o<=0.
  - redir & imem_ready_i: pc_o<=target; flush_o<=1 next cycle (one cycle wide). Redirect overrides stall_i.
  - redir & !imem_ready_i: latch target into pending, go to PEND, pc_o held, flush_o<=1 one cycle.
  - no redir: if imem_ready_i & !stall_i then pc_o<=pc_o+4 (wraps FFFF_FFFC->0000_0000), else hold.
- PEND:
  - pc_o held until imem_ready_i=1. Then pc_o<=pending and go to RUN.
  - A new redir in PEND overwrites pending with the new target (same priority rules) and pulses flush_o again. If that redir is also imem_ready_i cycle, pc_o<=new target and go to RUN.
  - stall_i is ignored in PEND.
- ERR: pc_o frozen, if_valid_o=0, all requests ignored; exit only by reset.
- redir_cnt_o increments by 1 when a branch-sourced redirect is accepted (RUN or PEND). Saturates at all-ones. Jumps and JR are not counted.
- flush_o is registered, never wider than one cycle per accepted redirect; back-to-back redirects produce consecutive pulses.
- br_taken_i without br_valid_i has no effect.

Test Plan:
- Reset, RESET_PC=0, imem_ready_i=1, no requests for 4 cycles -> BOOT 1 cycle, then pc_o 0,4,8,C; if_valid_o=1 from cycle 2.
- Branch: ex_pc4_i=0x100, br_offset_i=0xFFFF_FFF0, taken, imem_ready_i=1 -> pc_o=0xF0 next edge, flush_o=1 one cycle, redir_cnt_o=1.
- Redirect during memory wait: imem_ready_i=0, jmp_index_i=0x0000040, ex_pc4_i=0x8000_0010 -> pc_o held, flush_o pulse. When imem_ready_i=1 3 cycles later -> pc_o=0x8000_0100.
- Simultaneous jr_target_i=0x2000 and taken branch, with stall_i=1 -> pc_o=0x2000, redir_cnt_o unchanged.
- jr_target_i=0x2002 -> addr_err_o=1, if_valid_o=0, pc_o frozen for 5 cycles. rst_n low clears to BOOT.
- pc_o=0xFFFF_FFFC advancing -> 0x0000_0000. 2^CNT_W+2 taken branches -> redir_cnt_o stays at all-ones.
